// File: rtl/oka_pkg.sv
// oka_pkg: FSM state type, default field polynomial and a reference carry-less multiply
package oka_pkg;
  typedef enum logic [2:0] {IDLE, LO, MID, HI, DONE} state_t;
  localparam logic [31:0] DEFAULT_POLY = 32'h0000_008D;
  function automatic logic [127:0] clmul_ref(input logic [63:0] x, input logic [63:0] y, input int n);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < n; i++)
      if (y[i]) r = r ^ ({64'd0, x} << i);
    return r;
  endfunction
endpackage

// File: rtl/oka_clmul_core.sv
// oka_clmul_core: combinational schoolbook carry-less multiply, H x H -> 2H-1
module oka_clmul_core #(
  parameter int H = 16
) (
  input  logic [H-1:0]   x,
  input  logic [H-1:0]   y,
  output logic [2*H-2:0] p
);
  localparam int P = 2 * H - 1;
  always_comb begin
    p = '0;
    for (int i = 0; i < H; i++)
      p = p ^ (y[i] ? (P'(x) << i) : '0);
  end
endmodule

// File: rtl/oka_seq_mul.sv
// oka_seq_mul: sequential Karatsuba GF(2) multiplier on one shared half-width core; OKA_MOD_REDUCE_EN adds y_red
module oka_seq_mul
  import oka_pkg::*;
#(
  parameter int             W    = 32,
  parameter logic [W-1:0]   POLY = W'(DEFAULT_POLY)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [2*W-2:0] y,
  output logic           out_valid,
  input  logic           out_ready
`ifdef OKA_MOD_REDUCE_EN
  ,
  output logic [W-1:0]   y_red
`endif
);
  localparam int H = W / 2;
  state_t         state;
  logic [W-1:0]   ra, rb;
  logic [W-2:0]   z0, zm, zc, mid;
  logic [H-1:0]   cx, cy;
  logic [2*W-2:0] y_next;
  assign in_ready = state == IDLE;
  always_comb begin
    cx = state == LO ? ra[H-1:0] : state == MID ? ra[H-1:0] ^ ra[W-1:H] : ra[W-1:H];
    cy = state == LO ? rb[H-1:0] : state == MID ? rb[H-1:0] ^ rb[W-1:H] : rb[W-1:H];
  end
  oka_clmul_core #(.H(H)) u_core (.x(cx), .y(cy), .p(zc));
  // In HI the core output is z2; the middle term needs z0 and z2 removed from zm.
  assign mid    = zm ^ z0 ^ zc;
  assign y_next = {zc, {W{1'b0}}} ^ {{H{1'b0}}, mid, {H{1'b0}}} ^ {{W{1'b0}}, z0};
`ifdef OKA_MOD_REDUCE_EN
  logic [2*W-2:0] r;
  always_comb begin
    r = y_next;
    for (int i = 2 * W - 2; i >= W; i--)
      if (r[i]) r = r ^ ((2*W-1)'(POLY) << (i - W)) ^ ((2*W-1)'(1) << i);
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      y         <= '0;
      ra        <= '0;
      rb        <= '0;
      z0        <= '0;
      zm        <= '0;
`ifdef OKA_MOD_REDUCE_EN
      y_red     <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          ra    <= a;
          rb    <= b;
          state <= LO;
        end
        LO: begin
          z0    <= zc;
          state <= MID;
        end
        MID: begin
          zm    <= zc;
          state <= HI;
        end
        HI: begin
          y         <= y_next;
`ifdef OKA_MOD_REDUCE_EN
          y_red     <= r[W-1:0];
`endif
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
